// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter between instruction fetch and the load/store buffer
// for a byte-wide RAM port; each 1/2/4-byte access is sequenced one byte per cycle.
module mem_arbiter #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned IO_ADDR_BIT = 17
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_request_in,
    input  logic [ADDR_WIDTH-1:0] if_address_in,
    output logic                  if_ready_out,
    output logic [31:0]           if_data_out,
    input  logic                  lsb_request_in,
    input  logic                  lsb_write_in,
    input  logic [1:0]            lsb_size_in,
    input  logic [ADDR_WIDTH-1:0] lsb_address_in,
    input  logic [31:0]           lsb_data_in,
    output logic                  lsb_ready_out,
    output logic [31:0]           lsb_data_out,
    input  logic                  rollback_in,
    input  logic                  io_buffer_full_in,
    output logic                  ram_rw_out,
    output logic [ADDR_WIDTH-1:0] ram_addr_out,
    output logic [7:0]            ram_data_out,
    input  logic [7:0]            ram_data_in
);
    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    state_t                state_q, state_d;
    logic [2:0]            cnt_q, cnt_d, nbytes_q, nbytes_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic                  is_if_q, is_if_d, last_lsb_q, last_lsb_d;
    logic [31:0]           rbuf_q, rbuf_d, rbuf_next;
    logic                  if_pend_q, if_pend_d;
    logic [ADDR_WIDTH-1:0] if_addr_q, if_addr_d;
    logic                  lsb_pend_q, lsb_pend_d, lsb_wr_q, lsb_wr_d;
    logic [1:0]            lsb_size_q, lsb_size_d;
    logic [ADDR_WIDTH-1:0] lsb_addr_q, lsb_addr_d;
    logic [31:0]           lsb_wdata_q, lsb_wdata_d;
    logic                  ram_rw_d, if_ready_d, lsb_ready_d;
    logic [ADDR_WIDTH-1:0] ram_addr_d;
    logic [7:0]            ram_data_d;
    logic [31:0]           if_data_d, lsb_data_d;
    logic                  if_live, grant_if, grant_lsb, lsb_stall, cur_stall;
    logic [1:0]            rd_idx;
    logic [2:0]            lsb_n;

    // A rollback on this edge cancels a pending fetch before it can be granted.
    assign if_live   = if_pend_q && !rollback_in;
    assign grant_if  = if_live && (!lsb_pend_q || last_lsb_q);
    assign grant_lsb = lsb_pend_q && !grant_if;
    assign lsb_stall = (lsb_addr_q[IO_ADDR_BIT -: 2] == 2'b11) && io_buffer_full_in;
    assign cur_stall = (base_q[IO_ADDR_BIT -: 2] == 2'b11) && io_buffer_full_in;
    assign lsb_n     = (lsb_size_q == 2'd0) ? 3'd1 : (lsb_size_q == 2'd1) ? 3'd2 : 3'd4;
    assign rd_idx    = cnt_q[1:0] - 2'd1;

    always_comb begin
        rbuf_next = rbuf_q;
        rbuf_next[{rd_idx, 3'b000} +: 8] = ram_data_in;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        nbytes_d    = nbytes_q;
        base_d      = base_q;
        is_if_d     = is_if_q;
        last_lsb_d  = last_lsb_q;
        rbuf_d      = rbuf_q;
        if_pend_d   = if_pend_q;
        if_addr_d   = if_addr_q;
        lsb_pend_d  = lsb_pend_q;
        lsb_wr_d    = lsb_wr_q;
        lsb_size_d  = lsb_size_q;
        lsb_addr_d  = lsb_addr_q;
        lsb_wdata_d = lsb_wdata_q;
        ram_rw_d    = 1'b0;
        ram_addr_d  = ram_addr_out;
        ram_data_d  = ram_data_out;
        if_ready_d  = 1'b0;
        if_data_d   = if_data_out;
        lsb_ready_d = 1'b0;
        lsb_data_d  = lsb_data_out;

        if (rollback_in) begin
            if_pend_d = 1'b0;
        end else if (if_request_in && !if_pend_q) begin
            if_pend_d = 1'b1;
            if_addr_d = if_address_in;
        end
        if (lsb_request_in && !lsb_pend_q) begin
            lsb_pend_d  = 1'b1;
            lsb_wr_d    = lsb_write_in;
            lsb_size_d  = lsb_size_in;
            lsb_addr_d  = lsb_address_in;
            lsb_wdata_d = lsb_data_in;
        end

        case (state_q)
            IDLE: begin
                if (grant_if) begin
                    last_lsb_d = 1'b0;
                    is_if_d    = 1'b1;
                    base_d     = if_addr_q;
                    nbytes_d   = 3'd4;
                    rbuf_d     = '0;
                    ram_addr_d = if_addr_q;
                    cnt_d      = 3'd1;
                    state_d    = READ;
                end else if (grant_lsb) begin
                    last_lsb_d = 1'b1;
                    is_if_d    = 1'b0;
                    base_d     = lsb_addr_q;
                    nbytes_d   = lsb_n;
                    rbuf_d     = '0;
                    ram_addr_d = lsb_addr_q;
                    if (lsb_wr_q) begin
                        state_d = WRITE;
                        if (lsb_stall) begin
                            cnt_d = '0;
                        end else begin
                            ram_rw_d   = 1'b1;
                            ram_data_d = lsb_wdata_q[7:0];
                            cnt_d      = 3'd1;
                        end
                    end else begin
                        state_d = READ;
                        cnt_d   = 3'd1;
                    end
                end
            end
            READ: begin
                if (is_if_q && rollback_in) begin
                    state_d = IDLE;
                end else begin
                    rbuf_d = rbuf_next;
                    if (cnt_q < nbytes_q) begin
                        ram_addr_d = base_q + ADDR_WIDTH'(cnt_q);
                        cnt_d      = cnt_q + 3'd1;
                    end else begin
                        state_d = IDLE;
                        if (is_if_q) begin
                            if_ready_d = 1'b1;
                            if_data_d  = rbuf_next;
                            if_pend_d  = 1'b0;
                        end else begin
                            lsb_ready_d = 1'b1;
                            lsb_data_d  = rbuf_next;
                            lsb_pend_d  = 1'b0;
                        end
                    end
                end
            end
            WRITE: begin
                if (cnt_q < nbytes_q) begin
                    if (!cur_stall) begin
                        ram_rw_d   = 1'b1;
                        ram_addr_d = base_q + ADDR_WIDTH'(cnt_q);
                        ram_data_d = lsb_wdata_q[{cnt_q[1:0], 3'b000} +: 8];
                        cnt_d      = cnt_q + 3'd1;
                    end
                end else begin
                    state_d     = IDLE;
                    lsb_ready_d = 1'b1;
                    lsb_pend_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            nbytes_q      <= '0;
            base_q        <= '0;
            is_if_q       <= 1'b0;
            last_lsb_q    <= 1'b0;
            rbuf_q        <= '0;
            if_pend_q     <= 1'b0;
            if_addr_q     <= '0;
            lsb_pend_q    <= 1'b0;
            lsb_wr_q      <= 1'b0;
            lsb_size_q    <= '0;
            lsb_addr_q    <= '0;
            lsb_wdata_q   <= '0;
            ram_rw_out    <= 1'b0;
            ram_addr_out  <= '0;
            ram_data_out  <= '0;
            if_ready_out  <= 1'b0;
            if_data_out   <= '0;
            lsb_ready_out <= 1'b0;
            lsb_data_out  <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            nbytes_q      <= nbytes_d;
            base_q        <= base_d;
            is_if_q       <= is_if_d;
            last_lsb_q    <= last_lsb_d;
            rbuf_q        <= rbuf_d;
            if_pend_q     <= if_pend_d;
            if_addr_q     <= if_addr_d;
            lsb_pend_q    <= lsb_pend_d;
            lsb_wr_q      <= lsb_wr_d;
            lsb_size_q    <= lsb_size_d;
            lsb_addr_q    <= lsb_addr_d;
            lsb_wdata_q   <= lsb_wdata_d;
            ram_rw_out    <= ram_rw_d;
            ram_addr_out  <= ram_addr_d;
            ram_data_out  <= ram_data_d;
            if_ready_out  <= if_ready_d;
            if_data_out   <= if_data_d;
            lsb_ready_out <= lsb_ready_d;
            lsb_data_out  <= lsb_data_d;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by randomized
// transactions checked against a transaction-level memory model.
module tb_mem_arbiter;
    localparam int unsigned AW = 32;

    logic          clk;
    logic          rst;
    logic          if_request_in;
    logic [AW-1:0] if_address_in;
    logic          if_ready_out;
    logic [31:0]   if_data_out;
    logic          lsb_request_in;
    logic          lsb_write_in;
    logic [1:0]    lsb_size_in;
    logic [AW-1:0] lsb_address_in;
    logic [31:0]   lsb_data_in;
    logic          lsb_ready_out;
    logic [31:0]   lsb_data_out;
    logic          rollback_in;
    logic          io_buffer_full_in;
    logic          ram_rw_out;
    logic [AW-1:0] ram_addr_out;
    logic [7:0]    ram_data_out;
    logic [7:0]    ram_data_in;

    mem_arbiter #(.ADDR_WIDTH(AW), .IO_ADDR_BIT(17)) dut (
        .clk(clk), .rst(rst),
        .if_request_in(if_request_in), .if_address_in(if_address_in),
        .if_ready_out(if_ready_out), .if_data_out(if_data_out),
        .lsb_request_in(lsb_request_in), .lsb_write_in(lsb_write_in),
        .lsb_size_in(lsb_size_in), .lsb_address_in(lsb_address_in),
        .lsb_data_in(lsb_data_in), .lsb_ready_out(lsb_ready_out),
        .lsb_data_out(lsb_data_out), .rollback_in(rollback_in),
        .io_buffer_full_in(io_buffer_full_in), .ram_rw_out(ram_rw_out),
        .ram_addr_out(ram_addr_out), .ram_data_out(ram_data_out),
        .ram_data_in(ram_data_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  mem [0:65535];
    assign ram_data_in = mem[ram_addr_out[15:0]];

    logic [31:0]  if_q[$];
    logic [31:0]  lsb_q[$];
    int unsigned  if_cyc[$];
    int unsigned  lsb_cyc[$];
    logic         order[$];
    logic [39:0]  wlog[$];
    int unsigned  cyc, checks, errors, base_c;
    logic         last_lsb;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge and sample 1 time unit later; writes land in the model memory.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (ram_rw_out) begin
            mem[ram_addr_out[15:0]] = ram_data_out;
            wlog.push_back({ram_addr_out, ram_data_out});
        end
        if (if_ready_out) begin
            if_q.push_back(if_data_out); if_cyc.push_back(cyc); order.push_back(1'b0);
        end
        if (lsb_ready_out) begin
            lsb_q.push_back(lsb_data_out); lsb_cyc.push_back(cyc); order.push_back(1'b1);
        end
    endtask

    task automatic clear_logs();
        if_q.delete(); lsb_q.delete(); if_cyc.delete(); lsb_cyc.delete();
        order.delete(); wlog.delete();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        if_request_in = 1'b0; if_address_in = '0; lsb_request_in = 1'b0;
        lsb_write_in = 1'b0; lsb_size_in = '0; lsb_address_in = '0; lsb_data_in = '0;
        rollback_in = 1'b0; io_buffer_full_in = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        clear_logs();
    endtask

    task automatic set_if(input logic [31:0] a);
        if_request_in = 1'b1; if_address_in = a;
    endtask

    task automatic set_lsb(input logic wr, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        lsb_request_in = 1'b1; lsb_write_in = wr; lsb_size_in = sz;
        lsb_address_in = a; lsb_data_in = d;
    endtask

    task automatic pulse();
        tick();
        if_request_in = 1'b0; lsb_request_in = 1'b0;
        base_c = cyc;
    endtask

    task automatic wait_for(input int nif, input int nlsb, input string tag);
        int unsigned k;
        k = 0;
        while ((if_q.size() < nif || lsb_q.size() < nlsb) && k < 40) begin
            tick(); k++;
        end
        check(tag, {62'd0, if_q.size() >= nif, lsb_q.size() >= nlsb}, 64'd3);
    endtask

    function automatic int unsigned nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] rd_model(input logic [31:0] a, input int unsigned n);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < int'(n); i++) r[8*i +: 8] = mem[16'(a + 32'(i))];
        return r;
    endfunction

    task automatic check_writes(input logic [31:0] a, input logic [31:0] d, input int unsigned n);
        logic [39:0] e;
        check("wr_count", 64'(wlog.size()), 64'(n));
        for (int i = 0; i < int'(n); i++) begin
            e = {a + 32'(i), d[8*i +: 8]};
            check("wr_byte", 64'(wlog[i]), 64'(e));
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w, e_if, e_lsb;
        cyc = 0; checks = 0; errors = 0; base_c = 0; last_lsb = 1'b0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[16'h1000] = 8'h13; mem[16'h1001] = 8'h05;
        mem[16'h1002] = 8'h10; mem[16'h1003] = 8'h00;

        // Reset state
        do_reset();
        check("rst_rw", 64'(ram_rw_out), 64'd0);
        check("rst_addr", 64'(ram_addr_out), 64'd0);
        check("rst_wdata", 64'(ram_data_out), 64'd0);
        check("rst_if_rdy", 64'(if_ready_out), 64'd0);
        check("rst_if_data", 64'(if_data_out), 64'd0);
        check("rst_lsb_rdy", 64'(lsb_ready_out), 64'd0);
        check("rst_lsb_data", 64'(lsb_data_out), 64'd0);

        // Fetch only at 0x1000
        set_if(32'h1000); pulse();
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("fetch_addr", 64'(ram_addr_out), 64'(32'h1000 + 32'(i - 1)));
            check("fetch_rw", 64'(ram_rw_out), 64'd0);
            check("fetch_rdy_early", 64'(if_ready_out), 64'd0);
        end
        tick();
        check("fetch_rdy", 64'(if_ready_out), 64'd1);
        check("fetch_data", 64'(if_data_out), 64'h00100513);
        check("fetch_addr_hold", 64'(ram_addr_out), 64'h1003);
        tick();
        check("fetch_rdy_pulse", 64'(if_ready_out), 64'd0);
        check("fetch_data_hold", 64'(if_data_out), 64'h00100513);

        // Simultaneous pair after reset: LSB wins the first tie
        do_reset();
        mem[16'h0020] = 8'hA7;
        e_if = rd_model(32'h0, 4);
        set_if(32'h0); set_lsb(1'b0, 2'd0, 32'h20, 32'h0); pulse();
        wait_for(1, 1, "pair1_timeout");
        check("pair1_first", 64'(order[0]), 64'd1);
        check("pair1_second", 64'(order[1]), 64'd0);
        check("pair1_lsb_data", 64'(lsb_q[0]), 64'h000000A7);
        check("pair1_if_data", 64'(if_q[0]), 64'(e_if));
        check("pair1_lsb_lat", 64'(lsb_cyc[0] - base_c), 64'd2);
        check("pair1_if_lat", 64'(if_cyc[0] - base_c), 64'd7);
        clear_logs();

        // Store word 0xDEADBEEF at 0x100
        w = 32'hDEADBEEF;
        set_lsb(1'b1, 2'd2, 32'h100, w); pulse();
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("st_rw", 64'(ram_rw_out), 64'd1);
            check("st_addr", 64'(ram_addr_out), 64'(32'h100 + 32'(i - 1)));
            check("st_byte", 64'(ram_data_out), 64'(w[8*(i-1) +: 8]));
        end
        tick();
        check("st_rw_end", 64'(ram_rw_out), 64'd0);
        check("st_rdy", 64'(lsb_ready_out), 64'd1);
        clear_logs();

        // Second pair: last grant was the LSB, so IF goes first
        e_if = rd_model(32'h40, 4);
        e_lsb = rd_model(32'h60, 2);
        set_if(32'h40); set_lsb(1'b0, 2'd1, 32'h60, 32'h0); pulse();
        wait_for(1, 1, "pair2_timeout");
        check("pair2_first", 64'(order[0]), 64'd0);
        check("pair2_if_data", 64'(if_q[0]), 64'(e_if));
        check("pair2_lsb_data", 64'(lsb_q[0]), 64'(e_lsb));
        check("pair2_if_lat", 64'(if_cyc[0] - base_c), 64'd5);
        check("pair2_lsb_lat", 64'(lsb_cyc[0] - base_c), 64'd8);
        clear_logs();

        // Buffer full does not stall a store outside the I/O region
        io_buffer_full_in = 1'b1;
        set_lsb(1'b1, 2'd0, 32'h20000, 32'h77); pulse();
        tick();
        check("nonio_rw", 64'(ram_rw_out), 64'd1);
        tick();
        check("nonio_rdy", 64'(lsb_ready_out), 64'd1);

        // I/O stall: full for three grant/stall edges
        set_lsb(1'b1, 2'd0, 32'h30000, 32'h1234565A); pulse();
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("io_stall_rw", 64'(ram_rw_out), 64'd0);
        end
        io_buffer_full_in = 1'b0;
        tick();
        check("io_rw", 64'(ram_rw_out), 64'd1);
        check("io_addr", 64'(ram_addr_out), 64'h30000);
        check("io_byte", 64'(ram_data_out), 64'h5A);
        tick();
        check("io_rdy", 64'(lsb_ready_out), 64'd1);
        check("io_rw_end", 64'(ram_rw_out), 64'd0);
        clear_logs();

        // Rollback while fetch byte 2 is on the bus; a queued load still completes
        e_lsb = rd_model(32'h200, 2);
        set_if(32'h1000); pulse();
        tick();
        set_lsb(1'b0, 2'd1, 32'h200, 32'h0);
        tick();
        lsb_request_in = 1'b0;
        tick();
        check("rb_addr_b2", 64'(ram_addr_out), 64'h1002);
        rollback_in = 1'b1;
        tick();
        rollback_in = 1'b0;
        check("rb_rw", 64'(ram_rw_out), 64'd0);
        check("rb_addr_hold", 64'(ram_addr_out), 64'h1002);
        tick();
        check("rb_lsb_grant", 64'(ram_addr_out), 64'h200);
        tick(); tick();
        check("rb_lsb_rdy", 64'(lsb_ready_out), 64'd1);
        check("rb_lsb_data", 64'(lsb_data_out), 64'(e_lsb));
        repeat (6) tick();
        check("rb_no_if_rdy", 64'(if_q.size()), 64'd0);
        clear_logs();

        // A fetch request on a rollback edge is dropped
        set_if(32'h300); rollback_in = 1'b1; pulse();
        rollback_in = 1'b0;
        repeat (8) tick();
        check("rb_req_drop", 64'(if_q.size()), 64'd0);
        clear_logs();

        // Reset in the middle of a store, then a normal transaction
        set_lsb(1'b1, 2'd2, 32'h140, 32'hCAFEF00D); pulse();
        tick(); tick();
        check("mid_rw", 64'(ram_rw_out), 64'd1);
        check("mid_addr", 64'(ram_addr_out), 64'h141);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_rw", 64'(ram_rw_out), 64'd0);
        check("mid_rst_addr", 64'(ram_addr_out), 64'd0);
        check("mid_rst_wdata", 64'(ram_data_out), 64'd0);
        check("mid_rst_lsb_rdy", 64'(lsb_ready_out), 64'd0);
        tick(); tick();
        rst = 1'b1;
        tick(); tick();
        check("mid_no_rdy", 64'(lsb_q.size()), 64'd0);
        clear_logs();
        e_lsb = rd_model(32'h140, 4);
        set_lsb(1'b0, 2'd2, 32'h140, 32'h0); pulse();
        wait_for(0, 1, "post_rst_timeout");
        check("post_rst_data", 64'(lsb_q[0]), 64'(e_lsb));
        check("post_rst_lat", 64'(lsb_cyc[0] - base_c), 64'd5);
        last_lsb = 1'b1;
        tick();
        clear_logs();

        // Randomized transactions against the memory model
        for (int t = 0; t < 60; t++) begin
            int unsigned kind, n;
            logic [31:0] fa, la, ld;
            logic [1:0]  sz;
            logic        wr, win_lsb;
            kind = $urandom_range(0, 3);
            fa   = 32'($urandom_range(0, 32'h7FF0));
            sz   = 2'($urandom_range(0, 3));
            wr   = 1'($urandom_range(0, 1));
            n    = nbytes(sz);
            la   = wr ? 32'($urandom_range(32'h8000, 32'hFFF0)) : 32'($urandom_range(0, 32'h7FF0));
            ld   = $urandom;
            e_if  = rd_model(fa, 4);
            e_lsb = rd_model(la, n);
            clear_logs();
            if (kind != 1) set_if(fa);
            if (kind != 0) set_lsb(wr, sz, la, ld);
            pulse();
            wait_for((kind != 1) ? 1 : 0, (kind != 0) ? 1 : 0, "rnd_timeout");
            if (kind == 0) begin
                check("rnd_if_data", 64'(if_q[0]), 64'(e_if));
                check("rnd_if_lat", 64'(if_cyc[0] - base_c), 64'd5);
                last_lsb = 1'b0;
            end else begin
                if (kind == 1) begin
                    check("rnd_lsb_lat", 64'(lsb_cyc[0] - base_c), 64'(n + 1));
                    last_lsb = 1'b1;
                end else begin
                    win_lsb = !last_lsb;
                    check("rnd_pair_order", 64'(order[0]), 64'(win_lsb));
                    check("rnd_pair_if_data", 64'(if_q[0]), 64'(e_if));
                    last_lsb = !win_lsb;
                end
                if (wr) check_writes(la, ld, n);
                else    check("rnd_lsb_data", 64'(lsb_q[0]), 64'(e_lsb));
            end
            tick();
            check("rnd_rdy_low", {62'd0, if_ready_out, lsb_ready_out}, 64'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sits between the instruction fetcher, the load/store buffer and the byte-wide external RAM port.
- Latches one-cycle request pulses from each requester and arbitrates between them round-robin.
- Sequences each 1/2/4-byte access as consecutive byte RAM cycles and returns the assembled word with a one-cycle ready pulse.
- Handles ROB rollback by dropping or aborting fetch traffic, and stalls writes to the I/O region while the I/O buffer is full.

Parameters:
- ADDR_WIDTH, 32, byte address width on all ports.
- IO_ADDR_BIT, 17, I/O region is any address with bits [IO_ADDR_BIT:IO_ADDR_BIT-1] == 2'b11.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous reset, active-low (asserted when 0).
- if_request_in  in  1  one-cycle fetch request pulse.
- if_address_in  in  ADDR_WIDTH  fetch address, sampled with request.
- if_ready_out  out  1  one-cycle pulse, if_data_out valid.
- if_data_out  out  32  fetched instruction, little-endian.
- lsb_request_in  in  1  one-cycle load/store request pulse.
- lsb_write_in  in  1  1 = store, 0 = load, sampled with request.
- lsb_size_in  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as word.
- lsb_address_in  in  ADDR_WIDTH  access address.
- lsb_data_in  in  32  store data; low bytes used.
- lsb_ready_out  out  1  one-cycle completion pulse for load and store.
- lsb_data_out  out  32  load data, zero-extended.
- rollback_in  in  1  ROB rollback.
- io_buffer_full_in  in  1  external I/O buffer full.
- ram_rw_out  out  1  1 = write this cycle.
- ram_addr_out  out  ADDR_WIDTH  RAM byte address.
- ram_data_out  out  8  write byte.
- ram_data_in  in  8  read byte; valid the cycle after its address was driven.

Behaviour:
- Reset (rst = 0, asynchronous): state IDLE; all outputs 0; both pending flags 0; last_grant = IF, so the LSB wins the first tie.
- Request capture: a request pulse sets its pending flag and latches address, size, write and data.
  - A requester must not re-request before its ready pulse; a request that arrives while the same requester is already pending is ignored.
- Fetch requests are always 4 bytes. N = byte count, from lsb_size_in for LSB requests.
- IDLE:
  - If only one requester is pending, grant it.
  - If both are pending, grant the one that is not last_grant.
  - On the grant edge, update last_grant, drive byte 0 (address = base, ram_rw_out = write), set counter = 1, and go to READ or WRITE.
- READ:
  - Each edge captures ram_data_in into byte counter-1.
  - While counter < N, drive address base+counter with ram_rw_out = 0, then counter++.
  - At counter == N, capture the last byte, assert the requester's ready with the data, clear its pending flag, and return to IDLE.
  - Latency: N+1 edges from grant to ready (word: 5); the arbiter is idle-to-idle in N+1 cycles.
- WRITE:
  - Drives byte counter of lsb_data_in at base+counter with ram_rw_out = 1.
  - After byte N-1, the next edge drops ram_rw_out, pulses lsb_ready_out and returns to IDLE.
  - I/O stall: if the address is in the I/O region and io_buffer_full_in = 1, hold ram_rw_out = 0 and do not advance the counter. Resume when the buffer is not full. This also applies on the grant edge.
- Rollback: on the edge with rollback_in = 1:
  - Clear if_pending.
  - If the current transaction is a fetch, abort it: go to IDLE, ram_rw_out = 0, no if_ready_out pulse.
  - LSB transactions and the lsb_pending flag are unaffected.
  - A same-cycle if_request_in is dropped.
- ram_addr_out holds its last value when idle. Ready outputs are 0 in every cycle except their pulse. Data outputs hold until the next completion.
- Reset mid-transaction: the transaction is abandoned immediately; there is no partial ready.

Test Plan:
- Fetch only: if_request_in at 0x1000, RAM bytes 0x13,0x05,0x10,0x00 → ram_addr_out steps 0x1000..0x1003; 5 edges after grant if_ready_out pulses with if_data_out = 0x00100513.
- Simultaneous requests after reset: LSB byte load at 0x20 with IF at 0x0 → LSB served first (2 cycles, lsb_data_out = 0x000000XX), then IF; a second simultaneous pair is served IF first.
- Store word 0xDEADBEEF at 0x100 → writes EF,BE,AD,DE to 0x100..0x103 with ram_rw_out = 1 for exactly 4 cycles, then lsb_ready_out pulse.
- I/O stall: byte store to 0x30000 with io_buffer_full_in = 1 for 3 cycles → no write while full; write occurs on the first non-full edge, then ready.
- Rollback during fetch byte 2 → no if_ready_out, IDLE next cycle; a pending LSB load is then served normally.
- Reset mid-store: rst pulled low after byte 1 → outputs 0 immediately, no lsb_ready_out; a new request after reset completes normally.
